// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: round-robin 2:1 arbiter between the L1 icache (c0) and
// dcache (c1) and a single line-granular memory port. An in-order tracking
// FIFO records the source of every accepted request so that the in-order
// memory responses can be steered back to the client that issued them.
module l1_mem_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int ID_W        = 2
) (
    input  logic              clk,
    input  logic              rst,
    // client 0 (icache)
    input  logic              c0_req_valid,
    output logic              c0_req_ready,
    input  logic              c0_req_we,
    input  logic [ADDR_W-1:0] c0_req_addr,
    input  logic [DATA_W-1:0] c0_req_data,
    input  logic [ID_W-1:0]   c0_req_id,
    output logic              c0_resp_valid,
    input  logic              c0_resp_ready,
    output logic [DATA_W-1:0] c0_resp_data,
    output logic [ID_W-1:0]   c0_resp_id,
    // client 1 (dcache)
    input  logic              c1_req_valid,
    output logic              c1_req_ready,
    input  logic              c1_req_we,
    input  logic [ADDR_W-1:0] c1_req_addr,
    input  logic [DATA_W-1:0] c1_req_data,
    input  logic [ID_W-1:0]   c1_req_id,
    output logic              c1_resp_valid,
    input  logic              c1_resp_ready,
    output logic [DATA_W-1:0] c1_resp_data,
    output logic [ID_W-1:0]   c1_resp_id,
    // downstream memory
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic [ID_W-1:0]   mem_req_id,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_data,
    input  logic [ID_W-1:0]   mem_resp_id,
    output logic              busy
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    logic                   last_grant_q, last_grant_d;
    logic                   lock_q, lock_d;
    logic                   lock_src_q, lock_src_d;
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   busy_q, busy_d;

    logic grant_s;
    logic gnt_valid_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    logic push_s;
    logic pop_s;
    logic head_s;
    logic rsp_ok_s;

    assign fifo_full_s  = (count_q == CNT_FULL);
    assign fifo_empty_s = (count_q == CNT_ZERO);
    assign busy         = busy_q;

    // Grant selection: a stalled offer keeps its source, otherwise round-robin.
    always_comb begin
        grant_s = ~last_grant_q;
        if (lock_q) begin
            grant_s = lock_src_q;
        end else if (c0_req_valid && !c1_req_valid) begin
            grant_s = 1'b0;
        end else if (c1_req_valid && !c0_req_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = ~last_grant_q;
        end
    end

    // Request path: mux the granted client onto the memory port, gate on FIFO room.
    always_comb begin
        gnt_valid_s  = 1'b0;
        mem_req_we   = 1'b0;
        mem_req_addr = {ADDR_W{1'b0}};
        mem_req_data = {DATA_W{1'b0}};
        mem_req_id   = {ID_W{1'b0}};
        if (grant_s) begin
            gnt_valid_s  = c1_req_valid;
            mem_req_we   = c1_req_we;
            mem_req_addr = c1_req_addr;
            mem_req_data = c1_req_data;
            mem_req_id   = c1_req_id;
        end else begin
            gnt_valid_s  = c0_req_valid;
            mem_req_we   = c0_req_we;
            mem_req_addr = c0_req_addr;
            mem_req_data = c0_req_data;
            mem_req_id   = c0_req_id;
        end
        mem_req_valid = gnt_valid_s && !fifo_full_s && !rst;
        c0_req_ready  = !grant_s && mem_req_ready && !fifo_full_s && !rst;
        c1_req_ready  = grant_s && mem_req_ready && !fifo_full_s && !rst;
        push_s        = mem_req_valid && mem_req_ready;
    end

    // Response path: steer the memory response to the client at the FIFO head.
    always_comb begin
        head_s         = fifo_q[rd_ptr_q];
        rsp_ok_s       = mem_resp_valid && !fifo_empty_s && !rst;
        c0_resp_valid  = rsp_ok_s && !head_s;
        c1_resp_valid  = rsp_ok_s && head_s;
        c0_resp_data   = mem_resp_data;
        c1_resp_data   = mem_resp_data;
        c0_resp_id     = mem_resp_id;
        c1_resp_id     = mem_resp_id;
        mem_resp_ready = (head_s ? c1_resp_ready : c0_resp_ready) && !fifo_empty_s && !rst;
        pop_s          = mem_resp_valid && mem_resp_ready;
    end

    // Next-state for arbitration history, grant lock and the tracking FIFO.
    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_src_d   = lock_src_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = grant_s;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
            last_grant_d     = grant_s;
            lock_d           = 1'b0;
        end else if (mem_req_valid) begin
            lock_d     = 1'b1;
            lock_src_d = grant_s;
        end else begin
            lock_d = lock_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        busy_d = (count_d != CNT_ZERO);
    end

    // State registers; reset discards all in-flight tracking and favours c0 next.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            lock_q       <= 1'b0;
            lock_src_q   <= 1'b0;
            fifo_q       <= {OUTSTANDING{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            busy_q       <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
        end
    end

endmodule
